vend_txn_sequencer: RTL and testbench

//  Transaction controller in front of the vending_machine display/decision datapath.

---
 rtl/vend_pkg.sv | 25 ++
 rtl/vend_edge_det.sv | 28 ++
 rtl/vend_txn_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_vend_txn_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and default fare/width constants for the vending transaction sequencer.
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CREDIT   = 3'd1,
        ST_CHECK    = 3'd2,
        ST_DISPENSE = 3'd3,
        ST_CHANGE   = 3'd4
    } vend_state_e;

    localparam int CREDIT_W_DEF = 8;
    localparam int PRICE0_DEF   = 5;
    localparam int PRICE1_DEF   = 8;
    localparam int PRICE2_DEF   = 10;
    localparam int PRICE3_DEF   = 12;

    function automatic logic is_busy_state(input vend_state_e s);
        case (s)
            ST_CHECK, ST_DISPENSE, ST_CHANGE: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/vend_edge_det.sv
// Rising-edge detector: one history flop, rise is high for the first cycle x is seen high.
module vend_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic x,
    output logic rise
);

    logic x_q;
    logic x_d;

    // next value of the history flop
    always_comb begin
        x_d = x;
    end

    // history register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= 1'b0;
        end else begin
            x_q <= x_d;
        end
    end

    assign rise = x & ~x_q;

endmodule

// File: rtl/vend_txn_sequencer.sv
// Vending transaction controller: credit accumulation, fare check, dispense handshake,
// unit-by-unit change return and inactivity refund.
module vend_txn_sequencer
    import vend_pkg::*;
#(
    parameter int CREDIT_W    = CREDIT_W_DEF,
    parameter int MAX_CREDIT  = 99,
    parameter int TIMEOUT_CYC = 1000,
    parameter int PRICE0      = PRICE0_DEF,
    parameter int PRICE1      = PRICE1_DEF,
    parameter int PRICE2      = PRICE2_DEF,
    parameter int PRICE3      = PRICE3_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [3:0]          b_in,
    input  logic                buy,
    input  logic [1:0]          sel,
    input  logic                cancel,
    input  logic                disp_ack,
    output logic                disp_valid,
    output logic [1:0]          disp_sel,
    output logic                change_pulse,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                yes,
    output logic                no
);

    localparam int SUM_W = CREDIT_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYC);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    vend_state_e         state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] fare_q, fare_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [1:0]          disp_sel_q, disp_sel_d;
    logic                disp_valid_q, disp_valid_d;
    logic                change_pulse_q, change_pulse_d;
    logic                busy_q, busy_d;
    logic                yes_q, yes_d;
    logic                no_q, no_d;
    logic                armed_q, armed_d;

    logic load_rise_s, buy_rise_s, cancel_rise_s;
    logic load_ev_s, buy_ev_s, cancel_ev_s;

    vend_edge_det u_load_ed   (.clk(clk), .rst(rst), .x(load),   .rise(load_rise_s));
    vend_edge_det u_buy_ed    (.clk(clk), .rst(rst), .x(buy),    .rise(buy_rise_s));
    vend_edge_det u_cancel_ed (.clk(clk), .rst(rst), .x(cancel), .rise(cancel_rise_s));

    // The first edge after reset only primes the edge history, so a level held through reset is not an event.
    assign load_ev_s   = load_rise_s   & armed_q;
    assign buy_ev_s    = buy_rise_s    & armed_q;
    assign cancel_ev_s = cancel_rise_s & armed_q;

    function automatic logic [CREDIT_W-1:0] sat_add(input logic [CREDIT_W-1:0] a,
                                                    input logic [3:0]          b);
        logic [SUM_W-1:0] s;
        s = {1'b0, a} + SUM_W'(b);
        if (s > SUM_W'(MAX_CREDIT)) begin
            return CREDIT_W'(MAX_CREDIT);
        end else begin
            return s[CREDIT_W-1:0];
        end
    endfunction

    function automatic logic [CREDIT_W-1:0] price_of(input logic [1:0] s);
        case (s)
            2'b00:   return CREDIT_W'(PRICE0);
            2'b01:   return CREDIT_W'(PRICE1);
            2'b10:   return CREDIT_W'(PRICE2);
            default: return CREDIT_W'(PRICE3);
        endcase
    endfunction

    // next-state, credit datapath, timeout counter and output decode
    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        fare_d         = fare_q;
        timer_d        = timer_q;
        disp_sel_d     = disp_sel_q;
        disp_valid_d   = disp_valid_q;
        change_pulse_d = 1'b0;
        yes_d          = 1'b0;
        no_d           = 1'b0;
        armed_d        = 1'b1;

        case (state_q)
            ST_IDLE: begin
                timer_d = {TMR_W{1'b0}};
                if (load_ev_s && (b_in != 4'd0)) begin
                    credit_d = sat_add({CREDIT_W{1'b0}}, b_in);
                    state_d  = ST_CREDIT;
                end else if (buy_ev_s) begin
                    no_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CREDIT: begin
                if (cancel_ev_s) begin
                    timer_d = {TMR_W{1'b0}};
                    state_d = ST_CHANGE;
                end else if (buy_ev_s) begin
                    fare_d     = price_of(sel);
                    disp_sel_d = sel;
                    state_d    = ST_CHECK;
                end else if (load_ev_s) begin
                    credit_d = sat_add(credit_q, b_in);
                    timer_d  = {TMR_W{1'b0}};
                end else if (timer_q == TMR_LAST) begin
                    timer_d = {TMR_W{1'b0}};
                    state_d = ST_CHANGE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_CHECK: begin
                if (credit_q >= fare_q) begin
                    yes_d        = 1'b1;
                    credit_d     = credit_q - fare_q;
                    disp_valid_d = 1'b1;
                    state_d      = ST_DISPENSE;
                end else begin
                    no_d    = 1'b1;
                    timer_d = {TMR_W{1'b0}};
                    state_d = ST_CREDIT;
                end
            end
            ST_DISPENSE: begin
                if (disp_valid_q && disp_ack) begin
                    disp_valid_d = 1'b0;
                    if (credit_q != {CREDIT_W{1'b0}}) begin
                        state_d = ST_CHANGE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    disp_valid_d = disp_valid_q;
                end
            end
            ST_CHANGE: begin
                if (credit_q != {CREDIT_W{1'b0}}) begin
                    change_pulse_d = 1'b1;
                    credit_d       = credit_q - CREDIT_W'(1);
                    if (credit_q == CREDIT_W'(1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_CHANGE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                credit_d     = {CREDIT_W{1'b0}};
                disp_valid_d = 1'b0;
            end
        endcase

        busy_d = is_busy_state(state_d);
    end

    // state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            credit_q       <= {CREDIT_W{1'b0}};
            fare_q         <= {CREDIT_W{1'b0}};
            timer_q        <= {TMR_W{1'b0}};
            disp_sel_q     <= 2'b00;
            disp_valid_q   <= 1'b0;
            change_pulse_q <= 1'b0;
            busy_q         <= 1'b0;
            yes_q          <= 1'b0;
            no_q           <= 1'b0;
            armed_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            fare_q         <= fare_d;
            timer_q        <= timer_d;
            disp_sel_q     <= disp_sel_d;
            disp_valid_q   <= disp_valid_d;
            change_pulse_q <= change_pulse_d;
            busy_q         <= busy_d;
            yes_q          <= yes_d;
            no_q           <= no_d;
            armed_q        <= armed_d;
        end
    end

    assign disp_valid   = disp_valid_q;
    assign disp_sel     = disp_sel_q;
    assign change_pulse = change_pulse_q;
    assign credit       = credit_q;
    assign busy         = busy_q;
    assign yes          = yes_q;
    assign no           = no_q;

endmodule

// File: tb/tb_vend_txn_sequencer.sv
// Directed self-checking bench for vend_txn_sequencer with hand-computed expectations.
module tb_vend_txn_sequencer;

    localparam int TMO = 50;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [3:0] b_in;
    logic       buy;
    logic [1:0] sel;
    logic       cancel;
    logic       disp_ack;
    logic       disp_valid;
    logic [1:0] disp_sel;
    logic       change_pulse;
    logic [7:0] credit;
    logic       busy;
    logic       yes;
    logic       no;

    int n_cmp   = 0;
    int n_err   = 0;
    int overlap = 0;
    int p;
    int yn;

    vend_txn_sequencer #(.TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .load(load), .b_in(b_in), .buy(buy), .sel(sel),
        .cancel(cancel), .disp_ack(disp_ack), .disp_valid(disp_valid), .disp_sel(disp_sel),
        .change_pulse(change_pulse), .credit(credit), .busy(busy), .yes(yes), .no(no)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && ((yes & no) | (yes & change_pulse) | (no & change_pulse)))
            overlap++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input logic [3:0] v);
        b_in = v;
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
    endtask

    task automatic run_count(input int cycles, output int pulses, output int yesno);
        pulses = 0;
        yesno  = 0;
        for (int i = 0; i < cycles; i++) begin
            if (change_pulse) pulses++;
            if (yes || no) yesno++;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; load = 1'b1; b_in = 4'd5; buy = 1'b0; sel = 2'd0;
        cancel = 1'b0; disp_ack = 1'b0;
        repeat (2) tick();
        check_eq("rst_credit", credit, 0);
        check_eq("rst_outs", {disp_valid, change_pulse, busy, yes, no}, 0);

        // T1: load held through reset is not an event
        rst = 1'b0;
        repeat (3) tick();
        check_eq("held_load_no_credit", credit, 0);
        load = 1'b0;
        tick();

        buy = 1'b1; tick();
        check_eq("idle_buy_no", no, 1);
        check_eq("idle_buy_yes", yes, 0);
        buy = 1'b0; tick();
        check_eq("idle_no_pulse_width", no, 0);

        b_in = 4'd0; load = 1'b1; tick(); load = 1'b0; tick();
        check_eq("zero_coin_credit", credit, 0);
        check_eq("zero_coin_busy", busy, 0);
        disp_ack = 1'b1; tick(); disp_ack = 1'b0;
        check_eq("idle_ack_ignored", disp_valid, 0);

        // T2: credit 6, buy sel 0 (fare 5)
        b_in = 4'd6; load = 1'b1; tick();
        check_eq("t2_credit", credit, 6);
        load = 1'b0; tick();
        sel = 2'd0; buy = 1'b1; tick();
        check_eq("t2_check_busy", busy, 1);
        check_eq("t2_yes_early", yes, 0);
        tick();
        check_eq("t2_yes", yes, 1);
        check_eq("t2_credit_after", credit, 1);
        check_eq("t2_valid", disp_valid, 1);
        check_eq("t2_sel", disp_sel, 0);
        buy = 1'b0; tick();
        check_eq("t2_yes_width", yes, 0);
        check_eq("t2_valid_hold", disp_valid, 1);
        disp_ack = 1'b1; tick(); disp_ack = 1'b0;
        check_eq("t2_valid_drop", disp_valid, 0);
        run_count(10, p, yn);
        check_eq("t2_pulses", p, 1);
        check_eq("t2_end_credit", credit, 0);
        check_eq("t2_end_busy", busy, 0);

        // T3: insufficient credit, then cancel refund
        coin(4'd3);
        sel = 2'd1; buy = 1'b1; tick(); tick();
        check_eq("t3_no", no, 1);
        check_eq("t3_yes", yes, 0);
        check_eq("t3_credit", credit, 3);
        check_eq("t3_busy", busy, 0);
        buy = 1'b0; tick();
        cancel = 1'b1; tick(); cancel = 1'b0;
        check_eq("t3_cancel_busy", busy, 1);
        run_count(10, p, yn);
        check_eq("t3_pulses", p, 3);
        check_eq("t3_end_credit", credit, 0);

        // T4: saturation at 99, buy sel 3 (fare 12)
        for (int i = 0; i < 7; i++) coin(4'd15);
        check_eq("t4_sat", credit, 99);
        sel = 2'd3; buy = 1'b1; tick(); tick();
        check_eq("t4_yes", yes, 1);
        check_eq("t4_credit", credit, 87);
        check_eq("t4_sel", disp_sel, 3);
        buy = 1'b0; tick();
        disp_ack = 1'b1; tick(); disp_ack = 1'b0;
        run_count(100, p, yn);
        check_eq("t4_pulses", p, 87);
        check_eq("t4_yesno", yn, 0);
        check_eq("t4_end_busy", busy, 0);

        // T5: inactivity refund after exactly TMO cycles in CREDIT
        b_in = 4'd4; load = 1'b1; tick();
        check_eq("t5_credit", credit, 4);
        load = 1'b0;
        repeat (TMO - 1) tick();
        check_eq("t5_before_timeout", busy, 0);
        tick();
        check_eq("t5_at_timeout", busy, 1);
        run_count(10, p, yn);
        check_eq("t5_pulses", p, 4);
        check_eq("t5_end_busy", busy, 0);

        // T6: cancel beats buy on the same edge
        coin(4'd5);
        sel = 2'd0; cancel = 1'b1; buy = 1'b1; tick();
        cancel = 1'b0; buy = 1'b0;
        check_eq("t6_busy", busy, 1);
        run_count(10, p, yn);
        check_eq("t6_pulses", p, 5);
        check_eq("t6_no_yesno", yn, 0);

        // exact fare: dispense straight back to IDLE
        coin(4'd8);
        sel = 2'd1; buy = 1'b1; tick(); tick();
        check_eq("exact_yes", yes, 1);
        check_eq("exact_credit", credit, 0);
        buy = 1'b0;
        disp_ack = 1'b1; tick(); disp_ack = 1'b0;
        check_eq("exact_idle", busy, 0);
        run_count(5, p, yn);
        check_eq("exact_pulses", p, 0);

        // reset during DISPENSE with change owed
        coin(4'd15);
        sel = 2'd2; buy = 1'b1; tick(); tick();
        check_eq("rd_valid", disp_valid, 1);
        check_eq("rd_credit", credit, 5);
        buy = 1'b0;
        rst = 1'b1; #1;
        check_eq("rd_outs", {disp_valid, change_pulse, busy, yes, no}, 0);
        check_eq("rd_credit_clr", credit, 0);
        tick(); rst = 1'b0; tick();
        run_count(10, p, yn);
        check_eq("rd_no_change", p, 0);
        check_eq("rd_idle", busy, 0);

        check_eq("exclusive_pulses", overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
